prog_page_buffer: RTL and testbench



---
 rtl/prog_page_buffer_if.sv | 37 +++
 rtl/prog_page_buffer.sv | 173 +++++++++++++++++
 tb/tb_prog_page_buffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prog_page_buffer_if.sv
// Handshake bundle between the JTAG deserializer, the page buffer and the SPI flash programmer.
// PROG_PAGE_CSUM_EN adds the CSUM_OK status line.
interface prog_page_buffer_if #(
  parameter int unsigned DEPTH_LOG2 = 8
);
  logic [2:0]          MODE;
  logic [7:0]          IN_DATA;
  logic                IN_VALID;
  logic [7:0]          DATA2;
  logic                NEW_DATA2;
  logic                READY;
  logic                DONE;
  logic [DEPTH_LOG2:0] FILL_CNT;
  logic                OVERFLOW;
  logic                UNDERFLOW;
`ifdef PROG_PAGE_CSUM_EN
  logic                CSUM_OK;

  modport master (
    output MODE, IN_DATA, IN_VALID, NEW_DATA2,
    input  DATA2, READY, DONE, FILL_CNT, OVERFLOW, UNDERFLOW, CSUM_OK
  );
  modport slave (
    input  MODE, IN_DATA, IN_VALID, NEW_DATA2,
    output DATA2, READY, DONE, FILL_CNT, OVERFLOW, UNDERFLOW, CSUM_OK
  );
`else
  modport master (
    output MODE, IN_DATA, IN_VALID, NEW_DATA2,
    input  DATA2, READY, DONE, FILL_CNT, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  MODE, IN_DATA, IN_VALID, NEW_DATA2,
    output DATA2, READY, DONE, FILL_CNT, OVERFLOW, UNDERFLOW
  );
`endif
endinterface

// File: rtl/prog_page_buffer.sv
// Single-page byte buffer: fill one flash page from JTAG, then drain it to the SPI programmer.
// Optional PROG_PAGE_CSUM_EN adds XOR checksums of filled vs presented bytes on CSUM_OK.
module prog_page_buffer #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  prog_page_buffer_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PAGE_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = (DEPTH_LOG2+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LOAD,
    ST_DRAIN,
    ST_END
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]          data2_q, data2_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                mem_we;
  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          rd_byte;
  logic                mode_on;

  assign mode_on = (bus.MODE == 3'b110);
  assign rd_byte = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

`ifdef PROG_PAGE_CSUM_EN
  logic [7:0] csum_in_q, csum_in_d;
  logic [7:0] csum_out_q, csum_out_d;
  logic       csum_ok_q, csum_ok_d;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data2_d  = data2_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mem_we   = 1'b0;
`ifdef PROG_PAGE_CSUM_EN
    csum_in_d  = csum_in_q;
    csum_out_d = csum_out_q;
`endif
    if (!mode_on) begin
      // Leaving programming mode drops the session but keeps the sticky error flags.
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      data2_d  = '0;
      ready_d  = 1'b0;
`ifdef PROG_PAGE_CSUM_EN
      csum_in_d  = '0;
      csum_out_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          if (bus.NEW_DATA2) unf_d = 1'b1;
        end
        ST_FILL: begin
          if (bus.IN_VALID) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
`ifdef PROG_PAGE_CSUM_EN
            csum_in_d = csum_in_q ^ bus.IN_DATA;
`endif
            if (wr_ptr_d == PAGE_FULL) state_d = ST_LOAD;
          end
          if (bus.NEW_DATA2) unf_d = 1'b1;
        end
        ST_LOAD: begin
          data2_d  = mem_q[0];
          rd_ptr_d = PTR_ONE;
          ready_d  = 1'b1;
          state_d  = ST_DRAIN;
`ifdef PROG_PAGE_CSUM_EN
          csum_out_d = csum_out_q ^ mem_q[0];
`endif
          if (bus.IN_VALID)  ovf_d = 1'b1;
          if (bus.NEW_DATA2) unf_d = 1'b1;
        end
        ST_DRAIN: begin
          if (bus.IN_VALID) ovf_d = 1'b1;
          if (bus.NEW_DATA2) begin
            if (rd_ptr_q != PAGE_FULL) begin
              data2_d  = rd_byte;
              rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef PROG_PAGE_CSUM_EN
              csum_out_d = csum_out_q ^ rd_byte;
`endif
            end else begin
              done_d  = 1'b1;
              ready_d = 1'b0;
              state_d = ST_END;
            end
          end
        end
        ST_END: begin
          if (bus.IN_VALID)  ovf_d = 1'b1;
          if (bus.NEW_DATA2) unf_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef PROG_PAGE_CSUM_EN
    csum_ok_d = (state_d == ST_END) && (csum_in_d == csum_out_d);
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data2_q  <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef PROG_PAGE_CSUM_EN
      csum_in_q  <= '0;
      csum_out_q <= '0;
      csum_ok_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data2_q  <= data2_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef PROG_PAGE_CSUM_EN
      csum_in_q  <= csum_in_d;
      csum_out_q <= csum_out_d;
      csum_ok_q  <= csum_ok_d;
`endif
    end
  end

  // Page storage is never cleared; a stale page is simply overwritten by the next fill.
  always_ff @(posedge CLK) begin
    if (RST_N && mem_we) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.IN_DATA;
  end

  assign bus.DATA2     = data2_q;
  assign bus.READY     = ready_q;
  assign bus.DONE      = done_q;
  assign bus.FILL_CNT  = wr_ptr_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = unf_q;
`ifdef PROG_PAGE_CSUM_EN
  assign bus.CSUM_OK   = csum_ok_q;
`endif

endmodule

// File: tb/tb_prog_page_buffer.sv
// Randomized self-checking bench for prog_page_buffer against a byte-queue page model.
// Checksum scenarios run only when PROG_PAGE_CSUM_EN is defined.
module tb_prog_page_buffer;
  localparam int unsigned DL    = 8;
  localparam int unsigned DEPTH = 1 << DL;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  prog_page_buffer_if #(.DEPTH_LOG2(DL)) bus ();
  prog_page_buffer #(.DEPTH_LOG2(DL)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  logic [7:0] page [$];
  logic exp_ovf;
  logic exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IN_VALID  = 1'b0;
    bus.NEW_DATA2 = 1'b0;
    bus.IN_DATA   = '0;
  endtask

  // Writes n bytes (index values or random), with random gaps and occasional stray requests.
  task automatic fill_page(input int n, input bit idx_vals, input bit corrupt);
    logic [7:0] b;
    page.delete();
    for (int i = 0; i < n; i++) begin
      b = idx_vals ? 8'(i) : 8'($urandom);
      bus.IN_DATA  = b;
      bus.IN_VALID = 1'b1;
      if (!idx_vals && $urandom_range(0, 31) == 0) begin
        bus.NEW_DATA2 = 1'b1;
        exp_unf = 1'b1;
      end
      tick();
      idle_inputs();
      page.push_back(b);
      check("fill_cnt", 32'(bus.FILL_CNT), 32'(i + 1));
      check("unf_fill", 32'(bus.UNDERFLOW), 32'(exp_unf));
`ifdef PROG_PAGE_CSUM_EN
      if (corrupt && i == 200) begin
        dut.mem_q[5] = dut.mem_q[5] ^ 8'h5A;
        page[5] = page[5] ^ 8'h5A;
      end
`else
      if (corrupt) check("corrupt_unsupported", 32'(corrupt), 32'(0));
`endif
      if (i != n - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic expect_ready();
    check("ready_early", 32'(bus.READY), 32'(0));
    tick();
    check("ready_lat", 32'(bus.READY), 32'(1));
    check("data2_first", 32'(bus.DATA2), 32'(page[0]));
    check("fill_cnt_full", 32'(bus.FILL_CNT), 32'(DEPTH));
  endtask

  task automatic drain_page();
    int gap;
    for (int i = 1; i < DEPTH; i++) begin
      bus.NEW_DATA2 = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'($urandom);
        exp_ovf = 1'b1;
      end
      tick();
      idle_inputs();
      check("data2_step", 32'(bus.DATA2), 32'(page[i]));
      check("ready_drain", 32'(bus.READY), 32'(1));
      check("done_early", 32'(bus.DONE), 32'(0));
      check("ovf_drain", 32'(bus.OVERFLOW), 32'(exp_ovf));
      check("fill_cnt_drain", 32'(bus.FILL_CNT), 32'(DEPTH));
      gap = (i < 8) ? 0 : int'($urandom_range(0, 7));
      repeat (gap) begin
        tick();
        check("data2_hold", 32'(bus.DATA2), 32'(page[i]));
      end
    end
    bus.NEW_DATA2 = 1'b1;
    tick();
    idle_inputs();
    check("done_pulse", 32'(bus.DONE), 32'(1));
    check("ready_end", 32'(bus.READY), 32'(0));
    check("data2_last", 32'(bus.DATA2), 32'(page[DEPTH-1]));
    tick();
    check("done_once", 32'(bus.DONE), 32'(0));
    check("data2_end_hold", 32'(bus.DATA2), 32'(page[DEPTH-1]));
  endtask

  task automatic check_session_cleared(input string tag);
    check({tag, "_fill_cnt"}, 32'(bus.FILL_CNT), 32'(0));
    check({tag, "_data2"}, 32'(bus.DATA2), 32'(0));
    check({tag, "_ready"}, 32'(bus.READY), 32'(0));
    check({tag, "_done"}, 32'(bus.DONE), 32'(0));
    check({tag, "_ovf"}, 32'(bus.OVERFLOW), 32'(exp_ovf));
    check({tag, "_unf"}, 32'(bus.UNDERFLOW), 32'(exp_unf));
  endtask

  initial begin
    RST_N    = 1'b0;
    bus.MODE = 3'b000;
    idle_inputs();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    tick();
    tick();
    check_session_cleared("reset");

    // Page 1: index values, stray request in FILL.
    RST_N    = 1'b1;
    bus.MODE = 3'b110;
    tick();
    bus.NEW_DATA2 = 1'b1;
    tick();
    idle_inputs();
    exp_unf = 1'b1;
    check("unf_in_fill", 32'(bus.UNDERFLOW), 32'(1));
    check("fill_cnt_unf", 32'(bus.FILL_CNT), 32'(0));
    fill_page(DEPTH, 1'b1, 1'b0);
    expect_ready();
    drain_page();

    // END is inert: a write is dropped but flagged.
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 8'hA5;
    tick();
    idle_inputs();
    exp_ovf = 1'b1;
    check("ovf_end", 32'(bus.OVERFLOW), 32'(1));
    check("data2_end_write", 32'(bus.DATA2), 32'(page[DEPTH-1]));

    bus.MODE = 3'b000;
    tick();
    check_session_cleared("mode_exit");

    // Partial page abandoned by mode exit, then a fresh random page.
    bus.MODE = 3'b110;
    tick();
    fill_page(100, 1'b0, 1'b0);
    bus.MODE = 3'b000;
    tick();
    check_session_cleared("abort");
    bus.MODE = 3'b110;
    tick();
    check("fill_cnt_restart", 32'(bus.FILL_CNT), 32'(0));
    fill_page(DEPTH, 1'b0, 1'b0);
    expect_ready();
    drain_page();
`ifdef PROG_PAGE_CSUM_EN
    check("csum_ok_good", 32'(bus.CSUM_OK), 32'(1));
    bus.MODE = 3'b000;
    tick();
    check("csum_ok_cleared", 32'(bus.CSUM_OK), 32'(0));
    bus.MODE = 3'b110;
    tick();
    fill_page(DEPTH, 1'b0, 1'b1);
    expect_ready();
    drain_page();
    check("csum_ok_bad", 32'(bus.CSUM_OK), 32'(0));
`endif

    // Sticky flags survive mode exit, clear only on reset.
    bus.MODE = 3'b000;
    tick();
    check_session_cleared("mode_exit2");
    RST_N = 1'b0;
    tick();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_session_cleared("reset2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
